// File: rtl/game_state_controller.sv
// Game sequencer for the stickman runner: one-hot game status, coin score,
// round countdown in frames and a one-cycle round_start pulse.
module game_state_controller #(
  parameter logic [7:0]  START_KEY       = 8'h2C,
  parameter logic [7:0]  WIN_SCORE       = 8'd20,
  parameter logic [11:0] GAME_FRAMES     = 12'd3600,
  parameter logic [7:0]  END_HOLD_FRAMES = 8'd120
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic        coin_hit,
  input  logic        is_dead,
  output logic [3:0]  status,
  output logic [7:0]  score,
  output logic [11:0] frames_left,
  output logic        round_start
);

  // One-hot encoding doubles as the status output {waiting, playing, win, lose}.
  typedef enum logic [3:0] {
    S_WAITING = 4'b1000,
    S_PLAYING = 4'b0100,
    S_WIN     = 4'b0010,
    S_LOSE    = 4'b0001
  } state_t;

  state_t     state;
  logic       frame_clk_d;
  logic [7:0] key_d;
  logic [7:0] hold;
  logic       frame_tick;
  logic       key_press;
  logic       coin_wins;

  assign frame_tick = frame_clk & ~frame_clk_d;
  assign key_press  = (keycode == START_KEY) && (key_d != START_KEY);
  // Compare in 9 bits so score+1 cannot wrap before the threshold test.
  assign coin_wins  = ({1'b0, score} + 9'd1) >= {1'b0, WIN_SCORE};
  assign status     = state;

  // State register, edge detectors, score, countdown, hold counter and round_start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_WAITING;
      score       <= '0;
      frames_left <= GAME_FRAMES;
      round_start <= 1'b0;
      hold        <= '0;
      frame_clk_d <= 1'b0;
      key_d       <= '0;
    end else begin
      frame_clk_d <= frame_clk;
      key_d       <= keycode;
      round_start <= 1'b0;
      case (state)
        S_WAITING: begin
          if (key_press) begin
            state       <= S_PLAYING;
            round_start <= 1'b1;
            score       <= '0;
            frames_left <= GAME_FRAMES;
          end
        end
        S_PLAYING: begin
          // Death beats a winning coin, which beats the final timeout tick.
          if (is_dead) begin
            state <= S_LOSE;
            hold  <= '0;
          end else if (coin_hit && coin_wins) begin
            if (score != 8'hFF) score <= score + 8'd1;
            state <= S_WIN;
            hold  <= '0;
          end else if (frame_tick && frames_left == 12'd1) begin
            frames_left <= '0;
            state       <= S_LOSE;
            hold        <= '0;
          end else begin
            if (coin_hit && score != 8'hFF) score <= score + 8'd1;
            if (frame_tick && frames_left != '0) frames_left <= frames_left - 12'd1;
          end
        end
        S_WIN, S_LOSE: begin
          if (hold == END_HOLD_FRAMES) begin
            if (key_press) state <= S_WAITING;
          end else if (frame_tick) begin
            hold <= hold + 8'd1;
          end
        end
        default: state <= S_WAITING;
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller with a queue-based scoreboard.
module tb_game_state_controller;

  localparam logic [3:0] ST_WAIT = 4'b1000;
  localparam logic [3:0] ST_PLAY = 4'b0100;
  localparam logic [3:0] ST_WIN  = 4'b0010;
  localparam logic [3:0] ST_LOSE = 4'b0001;
  localparam logic [7:0] SPACE   = 8'h2C;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [7:0]  keycode;
  logic        coin_hit;
  logic        is_dead;
  logic [3:0]  status;
  logic [7:0]  score;
  logic [11:0] frames_left;
  logic        round_start;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [7:0]  sc;
    logic [11:0] fl;
    logic        rs;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   phase;
  int   pulses;

  game_state_controller #(
    .WIN_SCORE(8'd3),
    .GAME_FRAMES(12'd10),
    .END_HOLD_FRAMES(8'd4)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .keycode(keycode),
    .coin_hit(coin_hit),
    .is_dead(is_dead),
    .status(status),
    .score(score),
    .frames_left(frames_left),
    .round_start(round_start)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500us;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // One clock; frame_clk has a 20-cycle period, high for phases 0..9.
  task automatic clk1();
    @(posedge Clk);
    #1;
    phase = (phase == 19) ? 0 : phase + 1;
    frame_clk = (phase < 10);
  endtask

  // Advance through the next frame tick edge; afterwards 18 tick-free edges follow.
  task automatic align();
    while (phase != 0) clk1();
    clk1();
  endtask

  task automatic exp(input string tag, input logic [3:0] st, input logic [7:0] sc,
                     input logic [11:0] fl, input logic rs);
    exp_t e;
    e.tag = tag; e.st = st; e.sc = sc; e.fl = fl; e.rs = rs;
    q.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    total++;
    assert (q.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard_empty got=0 exp=1");
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      assert (status === e.st) else begin
        bad++;
        $error("FAIL %s status got=%b exp=%b", e.tag, status, e.st);
      end
      total++;
      assert (score === e.sc) else begin
        bad++;
        $error("FAIL %s score got=%0d exp=%0d", e.tag, score, e.sc);
      end
      total++;
      assert (frames_left === e.fl) else begin
        bad++;
        $error("FAIL %s frames_left got=%0d exp=%0d", e.tag, frames_left, e.fl);
      end
      total++;
      assert (round_start === e.rs) else begin
        bad++;
        $error("FAIL %s round_start got=%b exp=%b", e.tag, round_start, e.rs);
      end
    end
  endtask

  task automatic press_start();
    keycode = SPACE;
    exp("start", ST_PLAY, 8'd0, 12'd10, 1'b1);
    clk1(); chk();
    keycode = 8'h00;
    exp("start_next", ST_PLAY, 8'd0, 12'd10, 1'b0);
    clk1(); chk();
  endtask

  task automatic coin(input string tag, input logic [3:0] st, input logic [7:0] sc,
                      input logic [11:0] fl);
    coin_hit = 1'b1;
    exp(tag, st, sc, fl, 1'b0);
    clk1();
    coin_hit = 1'b0;
    chk();
  endtask

  // Sit out the end-screen hold, then leave it with a fresh space press.
  task automatic leave_end(input logic [3:0] st, input logic [7:0] sc, input logic [11:0] fl);
    repeat (4) align();
    exp("end_hold", st, sc, fl, 1'b0);
    chk();
    keycode = SPACE;
    exp("end_exit", ST_WAIT, sc, fl, 1'b0);
    clk1(); chk();
    keycode = 8'h00;
    clk1();
  endtask

  initial begin
    Reset = 1'b1; keycode = 8'h00; coin_hit = 1'b0; is_dead = 1'b0;
    phase = 10; frame_clk = 1'b0;
    clk1(); clk1();
    exp("reset", ST_WAIT, 8'd0, 12'd10, 1'b0);
    chk();
    Reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      repeat (20) clk1();
      exp("idle", ST_WAIT, 8'd0, 12'd10, 1'b0);
      chk();
    end

    // Held key: one pulse only; two ticks land inside the 50 cycles.
    align();
    keycode = SPACE;
    exp("press", ST_PLAY, 8'd0, 12'd10, 1'b1);
    clk1(); chk();
    pulses = 1;
    repeat (49) begin
      clk1();
      if (round_start === 1'b1) pulses++;
    end
    total++;
    assert (pulses === 1) else begin
      bad++;
      $error("FAIL held_key_pulses got=%0d exp=1", pulses);
    end
    exp("held_key", ST_PLAY, 8'd0, 12'd8, 1'b0);
    chk();
    keycode = 8'h00;

    align();
    exp("tick_dec", ST_PLAY, 8'd0, 12'd7, 1'b0);
    chk();
    coin("coin1", ST_PLAY, 8'd1, 12'd7);
    coin("coin2", ST_PLAY, 8'd2, 12'd7);
    coin("coin3_win", ST_WIN, 8'd3, 12'd7);
    align(); align();
    exp("win_frozen", ST_WIN, 8'd3, 12'd7, 1'b0);
    chk();
    align(); align();
    keycode = SPACE;
    exp("win_exit", ST_WAIT, 8'd3, 12'd7, 1'b0);
    clk1(); chk();
    keycode = 8'h00;
    clk1();

    // Timeout round: countdown to 0 then hold without wrapping.
    press_start();
    for (int k = 1; k <= 10; k++) begin
      align();
      exp("countdown", (k == 10) ? ST_LOSE : ST_PLAY, 8'd0, 12'(10 - k), 1'b0);
      chk();
    end
    align(); align();
    exp("no_wrap", ST_LOSE, 8'd0, 12'd0, 1'b0);
    chk();
    keycode = SPACE;
    exp("early_key", ST_LOSE, 8'd0, 12'd0, 1'b0);
    clk1(); chk();
    keycode = 8'h00;
    clk1();
    align(); align();
    keycode = SPACE;
    exp("lose_exit", ST_WAIT, 8'd0, 12'd0, 1'b0);
    clk1(); chk();
    keycode = 8'h00;
    clk1();

    // Coin and death in the same cycle.
    press_start();
    coin("r3_coin1", ST_PLAY, 8'd1, 12'd10);
    coin("r3_coin2", ST_PLAY, 8'd2, 12'd10);
    is_dead = 1'b1;
    coin("coin_dead", ST_LOSE, 8'd2, 12'd10);
    is_dead = 1'b0;
    leave_end(ST_LOSE, 8'd2, 12'd10);

    // Winning coin on the final timeout tick.
    press_start();
    coin("r4_coin1", ST_PLAY, 8'd1, 12'd10);
    coin("r4_coin2", ST_PLAY, 8'd2, 12'd10);
    repeat (9) align();
    exp("last_frame", ST_PLAY, 8'd2, 12'd1, 1'b0);
    chk();
    while (phase != 0) clk1();
    coin("coin_timeout", ST_WIN, 8'd3, 12'd1);
    leave_end(ST_WIN, 8'd3, 12'd1);

    // Reset in the middle of a round.
    press_start();
    coin("r5_coin1", ST_PLAY, 8'd1, 12'd10);
    coin("r5_coin2", ST_PLAY, 8'd2, 12'd10);
    Reset = 1'b1;
    exp("mid_reset", ST_WAIT, 8'd0, 12'd10, 1'b0);
    clk1(); chk();
    Reset = 1'b0;
    exp("after_reset", ST_WAIT, 8'd0, 12'd10, 1'b0);
    clk1(); chk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
Top-level game sequencer for the stickman runner. Owns the one-hot game status {waiting, playing, win, lose} that drives the colour mapper. Also owns the coin score, the round countdown and a one-cycle round_start pulse that re-initialises stickman, ground and coin generators. Sits between the keyboard keycode path, the gameplay collision logic and the VGA colour path; all timing is in vertical-sync frames.

Parameters:
START_KEY, 8'h2C, USB HID keycode that starts a round and leaves the end screens (space).
WIN_SCORE, 8'd20, coin count at which the round is won.
GAME_FRAMES, 12'd3600, round length in frames (60 s at 60 Hz); legal range 1..4095.
END_HOLD_FRAMES, 8'd120, frames the win/lose screen ignores keys.

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  synchronous, active-high reset
frame_clk  in  1  VGA vertical sync, asynchronous to frame logic; rising edge = new frame
keycode  in  8  current keyboard keycode, 8'h00 = no key
coin_hit  in  1  one-cycle pulse: stickman collected a coin
is_dead  in  1  level: stickman fell or hit an obstacle
status  out  4  one-hot {waiting, playing, win, lose}
score  out  8  coins collected this round
frames_left  out  12  remaining round frames
round_start  out  1  one-cycle pulse on entry to PLAYING

Behaviour:
- One clock; reset is synchronous and active-high (Clk, Reset); every register clears only on a Clk edge with Reset=1.
- Reset values: status=4'b1000 (WAITING), score=0, frames_left=GAME_FRAMES, round_start=0, hold counter=0, frame_clk_d=0, key_d=0.
- frame_tick = frame_clk & ~frame_clk_d, where frame_clk_d is frame_clk registered once. One tick per rising edge.
- key_press = (keycode==START_KEY) & (key_d!=START_KEY), where key_d is keycode registered once. A held key never produces a second press.
- All outputs are registered; status is the state register, not a decode of it.
- WAITING: on key_press, go to PLAYING next cycle. In the same cycle: round_start=1 for exactly one cycle, score<=0, frames_left<=GAME_FRAMES. coin_hit and is_dead are ignored.
- PLAYING, evaluated every cycle with priority 1 > 2 > 3:
  1) is_dead=1 -> LOSE.
  2) coin_hit=1 and score+1>=WIN_SCORE -> score<=score+1, go to WIN.
  3) frame_tick=1 and frames_left==1 -> frames_left<=0, go to LOSE (timeout).
- Otherwise in PLAYING:
  - coin_hit increments score, saturating at 8'hFF.
  - frame_tick decrements frames_left; frames_left never wraps below 0.
  - Keys are ignored.
- coin_hit together with is_dead in the same cycle: LOSE, and score is not incremented.
- coin_hit reaching WIN_SCORE together with the final timeout tick: WIN, and frames_left is left unchanged.
- Entry to WIN or LOSE clears the hold counter. score and frames_left freeze at their values at entry.
- WIN/LOSE: the hold counter increments on each frame_tick until it equals END_HOLD_FRAMES. Before that, key_press is ignored. Once the hold counter equals END_HOLD_FRAMES, key_press -> WAITING.
- On WAITING entry score and frames_left keep their frozen values; they reload only on the next round start.
- status is never 0 and never multi-hot. An illegal state register value recovers to WAITING on the next cycle.
- Reset asserted mid-round returns everything to reset values on the next edge; no round_start pulse is generated.

Test Plan:
The bench overrides WIN_SCORE=3, GAME_FRAMES=10, END_HOLD_FRAMES=4 and drives frame_clk with a period of 20 Clk cycles.
- Reset held 2 cycles, then released with idle inputs -> status=4'b1000, score=0, frames_left=10, round_start=0; 5 frames pass and nothing changes.
- keycode=8'h2C held 50 cycles while WAITING -> exactly one round_start pulse; status=4'b0100 one cycle after the press edge; frames_left=10.
- Three coin_hit pulses during PLAYING -> score steps 1, 2, 3; status=4'b0010 on the cycle after the third pulse; later ticks leave frames_left frozen.
- No coins for 10 frame ticks -> frames_left counts 10 down to 0; status=4'b0001 on the 10th tick; no wrap to 4095.
- Same-cycle events:
  - coin_hit and is_dead together at score=2 -> LOSE with score=2.
  - coin_hit at score=2 on the tick that takes frames_left 1->0 -> WIN with frames_left=1.
- In LOSE:
  - Space pressed after 2 ticks -> ignored.
  - Space pressed after 4 ticks -> WAITING.
  - Reset asserted mid-PLAYING at score=2 -> WAITING, score=0, frames_left=10, no round_start pulse.
